// File: rtl/ym2413_regfile.sv
// YM2413 register file: decodes bus writes into the chip's register map and
// registers the slot-selected channel's parameters. Optional debug readback under YM2413_REG_READBACK_EN.
module ym2413_regfile #(
  parameter int NUM_CH        = 9,
  parameter int RHY_INST_BASE = 16
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        write_addr,
  input  logic        write_data,
  input  logic [7:0]  data_reg,
  input  logic        slot_en,
  input  logic [3:0]  ch_idx,
  output logic [8:0]  fnum,
  output logic [2:0]  block,
  output logic        key_on,
  output logic        sus_on,
  output logic [4:0]  inst,
  output logic [3:0]  vol,
  output logic        rhythm,
  output logic [4:0]  rhy_key,
  output logic [63:0] cust_inst,
  output logic [7:0]  test_reg
`ifdef YM2413_REG_READBACK_EN
  ,
  input  logic        dbg_rd,
  output logic [7:0]  dbg_data
`endif
);

  logic [7:0] addr_q;
  logic       addr_valid;

  // Per-channel storage; ctl holds {sus, key, block[2:0], fnum[8]}.
  logic [7:0] fnum_lo [NUM_CH];
  logic [5:0] ctl     [NUM_CH];
  logic [3:0] inst_q  [NUM_CH];
  logic [3:0] vol_q   [NUM_CH];

  logic [3:0] a_hi, a_lo;
  logic       a_ch_ok, wr_en;

  assign a_hi    = addr_q[7:4];
  assign a_lo    = addr_q[3:0];
  assign a_ch_ok = (a_lo < 4'(NUM_CH));
  // An address strobe wins over a coincident data strobe.
  assign wr_en   = write_data & addr_valid & ~write_addr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what gives slot_en its no-bypass behaviour.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      addr_q     <= '0;
      addr_valid <= 1'b0;
    end else if (write_addr) begin
      addr_q     <= data_reg;
      addr_valid <= 1'b1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      cust_inst <= '0;
      rhythm    <= 1'b0;
      rhy_key   <= '0;
      test_reg  <= '0;
      // NOTE: the register array is small and must read as zero after reset,
      // so it is cleared element by element rather than left as RAM.
      for (int i = 0; i < NUM_CH; i++) begin
        fnum_lo[i] <= '0;
        ctl[i]     <= '0;
        inst_q[i]  <= '0;
        vol_q[i]   <= '0;
      end
    end else if (wr_en) begin
      case (a_hi)
        4'h0: begin
          if (!a_lo[3]) begin
            cust_inst[{a_lo[2:0], 3'b000} +: 8] <= data_reg;
          end else if (a_lo == 4'hE) begin
            rhythm  <= data_reg[5];
            rhy_key <= data_reg[4:0];
          end else if (a_lo == 4'hF) begin
            test_reg <= data_reg;
          end
        end
        4'h1: if (a_ch_ok) fnum_lo[a_lo] <= data_reg;
        4'h2: if (a_ch_ok) ctl[a_lo] <= data_reg[5:0];
        4'h3: if (a_ch_ok) begin
          inst_q[a_lo] <= data_reg[7:4];
          vol_q[a_lo]  <= data_reg[3:0];
        end
        default: ;
      endcase
    end
  end

  logic [8:0] fnum_c;
  logic [2:0] block_c;
  logic       key_c, sus_c;
  logic [4:0] inst_c;
  logic [3:0] vol_c;
  logic       rhy_ch;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    fnum_c  = '0;
    block_c = '0;
    key_c   = 1'b0;
    sus_c   = 1'b0;
    inst_c  = '0;
    vol_c   = '0;
    rhy_ch  = rhythm && (ch_idx >= 4'd6) && (ch_idx <= 4'd8);
    if (ch_idx < 4'(NUM_CH)) begin
      fnum_c  = {ctl[ch_idx][0], fnum_lo[ch_idx]};
      block_c = ctl[ch_idx][3:1];
      key_c   = ctl[ch_idx][4];
      sus_c   = ctl[ch_idx][5];
      inst_c  = {1'b0, inst_q[ch_idx]};
      vol_c   = vol_q[ch_idx];
      if (rhy_ch) begin
        inst_c = 5'(RHY_INST_BASE) + 5'(ch_idx - 4'd6);
        // rhy_key bit order is {BD, SD, TOM, TCY, HH}.
        case (ch_idx)
          4'd6:    key_c = key_c | rhy_key[4];
          4'd7:    key_c = key_c | rhy_key[0] | rhy_key[3];
          default: key_c = key_c | rhy_key[2] | rhy_key[1];
        endcase
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      fnum   <= '0;
      block  <= '0;
      key_on <= 1'b0;
      sus_on <= 1'b0;
      inst   <= '0;
      vol    <= '0;
    end else if (slot_en) begin
      fnum   <= fnum_c;
      block  <= block_c;
      key_on <= key_c;
      sus_on <= sus_c;
      inst   <= inst_c;
      vol    <= vol_c;
    end
  end

`ifdef YM2413_REG_READBACK_EN
  logic [7:0] rd_c;

  always_comb begin
    rd_c = '0;
    case (a_hi)
      4'h0: begin
        if (!a_lo[3])           rd_c = cust_inst[{a_lo[2:0], 3'b000} +: 8];
        else if (a_lo == 4'hE)  rd_c = {2'b00, rhythm, rhy_key};
        else if (a_lo == 4'hF)  rd_c = test_reg;
      end
      4'h1: if (a_ch_ok) rd_c = fnum_lo[a_lo];
      4'h2: if (a_ch_ok) rd_c = {2'b00, ctl[a_lo]};
      4'h3: if (a_ch_ok) rd_c = {inst_q[a_lo], vol_q[a_lo]};
      default: ;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (reset)       dbg_data <= '0;
    else if (dbg_rd) dbg_data <= addr_valid ? rd_c : 8'h00;
  end
`endif

endmodule

// File: doc/ym2413_regfile.md
Name: ym2413_regfile

Overview:
Register file sitting directly downstream of the YM2413 bus front-end.
- Consumes the address-write strobe, data-write strobe and latched data byte.
- Decodes the YM2413 register map into custom-instrument, rhythm, test and per-channel registers.
- Presents the parameters of the channel selected by the slot FSM to the operator pipeline, one channel per slot strobe.

Parameters:
NUM_CH, 9, number of melodic channels (fixed map 0x10-0x18, 0x20-0x28, 0x30-0x38)
RHY_INST_BASE, 16, instrument index reported for rhythm channels 6..8 (base+ch-6)

Ports:
MCLK  in  1  master clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
write_addr  in  1  one-MCLK pulse: data_reg is a register address
write_data  in  1  one-MCLK pulse: data_reg is register data
data_reg  in  8  latched bus byte
slot_en  in  1  one-MCLK strobe from slot clock; samples ch_idx
ch_idx  in  4  channel selected by slot FSM (0..8 valid)
fnum  out  9  F-number of selected channel
block  out  3  octave of selected channel
key_on  out  1  key bit of selected channel (rhythm OR applied)
sus_on  out  1  sustain bit of selected channel
inst  out  5  instrument index of selected channel
vol  out  4  volume/attenuation of selected channel
rhythm  out  1  reg 0x0E bit5
rhy_key  out  5  reg 0x0E bits4:0 (BD,SD,TOM,TCY,HH)
cust_inst  out  64  regs 0x00..0x07, byte n at bits 8n+7:8n
test_reg  out  8  reg 0x0F

Behaviour:
- Reset: all registers 0, address latch invalid, every output 0. Reset mid-write discards the write.
- write_addr: latch data_reg as address and set addr_valid. The latch is retained after data writes, so repeated data writes hit the same register.
- write_data with addr_valid: data_reg written to the decoded register on the same MCLK edge. Without addr_valid the write is ignored.
- Simultaneous write_addr and write_data: the address is latched and the data is dropped.
- Decode:
  - 0x00-0x07 cust_inst.
  - 0x0E rhythm/rhy_key (bits7:6 ignored).
  - 0x0F test.
  - 0x1n fnum[7:0].
  - 0x2n: bit5 sus, bit4 key, bits3:1 block, bit0 fnum[8].
  - 0x3n: bits7:4 inst, bits3:0 vol.
  - n = 0..8 only.
- All other addresses (0x08-0x0D, 0x19-0x1F, 0x29-0x2F, 0x39-0xFF, etc.): write ignored, no state change.
- Channel output stage:
  - On slot_en, the selected channel's fields are registered to the outputs; they are valid on the next MCLK and hold until the next slot_en.
  - A register write during slot_en to the selected channel: the output reflects the pre-write value (no bypass).
  - ch_idx > 8: fnum/block/key_on/sus_on/inst/vol all 0.
- Rhythm override, rhythm=1, ch_idx 6..8:
  - inst = RHY_INST_BASE+(ch_idx-6).
  - key_on = reg key bit OR ch6: BD; ch7: HH|SD; ch8: TOM|TCY.
  - fnum/block/vol pass through unchanged.
- rhythm=0: inst = zero-extended reg inst, key_on = reg key bit.
- rhythm, rhy_key, cust_inst, test_reg: continuous register values; they update on the write edge.

Optional Feature:
Macro YM2413_REG_READBACK_EN.
- Defined: adds input dbg_rd (1) and output dbg_data (8).
  - dbg_rd pulse with addr_valid: dbg_data = raw stored byte at the latched address, one MCLK later, held until the next dbg_rd.
  - Unused bits of 0x2n/0x0E read as 0.
  - Invalid/unmapped address, or no addr_valid: 0x00.
  - Reset clears dbg_data.
- Undefined: no dbg ports, no readback mux. All other behaviour identical.

Test Plan:
- Reset, then slot_en ch_idx=0 -> all outputs 0. write_data 0x55 with no prior address -> no register changes.
- write_addr 0x13, write_data 0xA5; write_addr 0x23, write_data 0x3B; write_addr 0x33, write_data 0x7C; slot_en ch_idx=3 -> next MCLK: fnum=0x1A5, block=5, sus_on=1, key_on=1, inst=7, vol=0xC.
- write_addr 0x0E, data 0x31 (rhythm=1, BD=1, HH=1); slot_en ch 6 -> inst=16, key_on=1. Same for ch 7 -> inst=17, key_on=1. Same for ch 8 with reg key=0 -> inst=18, key_on=0.
- Same MCLK write_addr+write_data 0x19 -> address 0x19 latched, nothing written. Subsequent write_data 0xFF -> ignored (unmapped). slot_en ch_idx=9 -> channel outputs 0.
- write_addr 0x05, data 0x81, then data 0x42 -> cust_inst[47:40]=0x42. Reset asserted mid-sequence -> cust_inst=0, next write_data ignored until a new write_addr.
- (YM2413_REG_READBACK_EN) write_addr 0x23, data 0xFF, dbg_rd -> dbg_data=0x3F one MCLK later. write_addr 0x0A, dbg_rd -> 0x00.
